// File: rtl/sqrt_pkg.sv
// Shared constants for the integer square-root unit: default width and FSM state encoding.
package sqrt_pkg;

  localparam int unsigned SQRT_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t LOAD = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/sqrt_step.sv
// One iteration of the restoring digit-by-digit square root: consumes one operand bit pair.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int unsigned HW = SQRT_WIDTH / 2
) (
  input  logic [HW+1:0] rem,
  input  logic [HW-1:0] root,
  input  logic [1:0]    pair,
  output logic [HW+1:0] rem_nxt,
  output logic [HW-1:0] root_nxt
);

  localparam int unsigned REM_W   = HW + 2;
  localparam int unsigned TRIAL_W = REM_W + 1;

  logic [TRIAL_W-1:0] cur;
  logic [TRIAL_W-1:0] sub;
  logic [TRIAL_W-1:0] trial;
  logic               neg;

  // Top bit of rem is always zero here, so the shifted value fits and the MSB acts as sign.
  always_comb begin
    cur      = TRIAL_W'({rem, pair});
    sub      = TRIAL_W'({root, 2'b01});
    trial    = cur - sub;
    neg      = trial[TRIAL_W-1];
    rem_nxt  = neg ? REM_W'(cur) : REM_W'(trial);
    root_nxt = HW'({root, ~neg});
  end

endmodule

// File: rtl/sqrt_unit.sv
// Free-running multi-cycle floor(sqrt(valor)), one result bit per clock.
// Optional SQRT_REMAINDER_EN adds rem_out = valor - sqrt^2.
module sqrt_unit
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = SQRT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   valor,
  output logic               endop,
  output logic [WIDTH/2-1:0] sqrt
`ifdef SQRT_REMAINDER_EN
  ,
  output logic [WIDTH/2:0]   rem_out
`endif
);

  localparam int unsigned HW    = WIDTH / 2;
  localparam int unsigned REM_W = HW + 2;
  localparam int unsigned CNT_W = (HW > 1) ? $clog2(HW) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [HW-1:0]    root_q, root_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]    sqrt_d;
  logic             endop_d;
  logic [REM_W-1:0] step_rem;
  logic [HW-1:0]    step_root;
`ifdef SQRT_REMAINDER_EN
  logic [HW:0]      rem_out_d;
`endif

  // The operand shifts left each CALC cycle, so the current pair is always at the top.
  sqrt_step #(
    .HW(HW)
  ) u_step (
    .rem      (rem_q),
    .root     (root_q),
    .pair     (op_q[WIDTH-1 -: 2]),
    .rem_nxt  (step_rem),
    .root_nxt (step_root)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    sqrt_d  = sqrt;
    endop_d = 1'b0;
`ifdef SQRT_REMAINDER_EN
    rem_out_d = rem_out;
`endif
    case (state_q)
      LOAD: begin
        op_d    = valor;
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = CNT_W'(HW - 1);
        state_d = CALC;
      end
      CALC: begin
        rem_d  = step_rem;
        root_d = step_root;
        op_d   = {op_q[WIDTH-3:0], 2'b00};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        sqrt_d  = root_q;
        endop_d = 1'b1;
`ifdef SQRT_REMAINDER_EN
        rem_out_d = (HW + 1)'(rem_q);
`endif
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= LOAD;
      op_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      sqrt    <= '0;
      endop   <= 1'b0;
`ifdef SQRT_REMAINDER_EN
      rem_out <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      sqrt    <= sqrt_d;
      endop   <= endop_d;
`ifdef SQRT_REMAINDER_EN
      rem_out <= rem_out_d;
`endif
    end
  end

endmodule

// File: tb/tb_sqrt_unit.sv
// Scoreboard bench for sqrt_unit: stimulus pushes expected results, a negedge monitor checks them.
module tb_sqrt_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] valor = '0;
  logic        endop;
  logic [7:0]  sqrt;
`ifdef SQRT_REMAINDER_EN
  logic [8:0]  rem_out;
`endif

  sqrt_unit #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .valor   (valor),
    .endop   (endop),
    .sqrt    (sqrt)
`ifdef SQRT_REMAINDER_EN
    ,
    .rem_out (rem_out)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned root;
    int unsigned rm;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Called at a negedge just before a LOAD edge; endop is due 10 edges later.
  task automatic issue(string name, logic [15:0] v, int unsigned root, int unsigned rm);
    valor = v;
    sb.push_back('{root, rm, cyc + 10, name});
    repeat (10) @(negedge clock);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (endop) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_endop: endop high at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_sqrt"}, sqrt, e.root);
        chk({e.name, "_latency"}, cyc, e.due);
`ifdef SQRT_REMAINDER_EN
        chk({e.name, "_rem"}, rem_out, e.rm);
`endif
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      chk({e.name, "_endop_timeout"}, cyc, e.due);
    end
  end

  initial begin
    reset = 1'b0;
    valor = '0;
    repeat (3) @(negedge clock);
    chk("reset_endop", endop, 0);
    chk("reset_sqrt", sqrt, 0);
    reset = 1'b1;

    issue("v4", 16'd4, 2, 0);
    issue("v16", 16'd16, 4, 0);
    issue("v25", 16'd25, 5, 0);
    issue("v36", 16'd36, 6, 0);
    issue("v49", 16'd49, 7, 0);
    issue("v225", 16'd225, 15, 0);
    issue("v0", 16'd0, 0, 0);
    issue("v65535", 16'd65535, 255, 510);
    issue("v1", 16'd1, 1, 0);
    issue("v24", 16'd24, 4, 8);
    issue("v226", 16'd226, 15, 1);

    // operand changes while the previous value is being computed
    valor = 16'd225;
    sb.push_back('{15, 0, cyc + 10, "v225_held"});
    repeat (3) @(negedge clock);
    valor = 16'd4;
    repeat (7) @(negedge clock);
    issue("v4_after_change", 16'd4, 2, 0);

    // reset during CALC discards the operation and clears the result
    valor = 16'd225;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_endop", endop, 0);
    chk("midreset_sqrt", sqrt, 0);
`ifdef SQRT_REMAINDER_EN
    chk("midreset_rem", rem_out, 0);
`endif
    reset = 1'b1;
    issue("v36_after_reset", 16'd36, 6, 0);
    issue("v49_after_reset", 16'd49, 7, 0);

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
